i2c_target_regs: RTL and testbench

//  I2C target (responder) for the board I2C buses, which the Qsys I2C hosts drive (temp/eeprom style:
//  *_in sense, *_oe pulls low). Exposes a byte-addressed register window to fabric logic.

---
 rtl/i2c_target_regs.sv | 274 +++++++++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regs.sv
// rtl/i2c_target_regs.sv - I2C target exposing a byte-addressed register window with auto-increment pointer
module i2c_target_regs #(
    parameter logic [6:0] DEV_ADDR = 7'h3A,
    parameter int         AW       = 3,
    parameter int         FILT     = 3
) (
    input  logic          clk_clk,
    input  logic          reset_reset,
    input  logic          scl_in,
    input  logic          sda_in,
    output logic          scl_oe,
    output logic          sda_oe,
    output logic          wr_stb,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic [AW-1:0] rd_addr,
    input  logic [7:0]    rd_data,
    output logic          rd_req,
    output logic          busy
);

    localparam int CW = (FILT < 2) ? 1 : $clog2(FILT + 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP
    } state_t;

    // index 0 carries SCL, index 1 carries SDA
    logic [1:0]    meta, sync, filt, filt_q;
    logic [CW-1:0] fcnt [2];

    state_t        state, state_d;
    logic [2:0]    bit_cnt, bit_cnt_d;
    logic [7:0]    shreg, shreg_d;
    logic [AW-1:0] ptr, ptr_d;
    logic [AW-1:0] wr_addr_d, rd_addr_d;
    logic [7:0]    wr_data_d;
    logic [7:0]    rd_buf;
    logic          ack_on, ack_on_d;
    logic          rw, rw_d;
    logic          got_ack, got_ack_d;
    logic          sda_oe_d, wr_stb_d, rd_req_d, busy_d;
    logic          rd_req_q;

    logic scl, sda, scl_q, sda_q;
    logic scl_rise, scl_fall, start_ev, stop_ev;
    logic [7:0] byte_in;

    assign scl_oe   = 1'b0;
    assign scl      = filt[0];
    assign sda      = filt[1];
    assign scl_q    = filt_q[0];
    assign sda_q    = filt_q[1];
    assign scl_rise = scl & ~scl_q;
    assign scl_fall = ~scl & scl_q;
    assign start_ev = scl & scl_q & sda_q & ~sda;
    assign stop_ev  = scl & scl_q & ~sda_q & sda;
    assign byte_in  = {shreg[6:0], sda};

    // Synchronise both pins and accept a new level only after FILT stable cycles
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            meta    <= 2'b11;
            sync    <= 2'b11;
            filt    <= 2'b11;
            filt_q  <= 2'b11;
            fcnt[0] <= '0;
            fcnt[1] <= '0;
        end else begin
            meta   <= {sda_in, scl_in};
            sync   <= meta;
            filt_q <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == CW'(FILT - 1)) begin
                    filt[i] <= sync[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 1'b1;
                end
            end
        end
    end

    // Capture fabric read data one cycle after the request pulse
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            rd_req_q <= 1'b0;
            rd_buf   <= '0;
        end else begin
            rd_req_q <= rd_req;
            if (rd_req_q) begin
                rd_buf <= rd_data;
            end
        end
    end

    // Protocol state and datapath registers
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            ptr     <= '0;
            wr_addr <= '0;
            wr_data <= '0;
            rd_addr <= '0;
            ack_on  <= 1'b0;
            rw      <= 1'b0;
            got_ack <= 1'b0;
            sda_oe  <= 1'b0;
            wr_stb  <= 1'b0;
            rd_req  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_d;
            bit_cnt <= bit_cnt_d;
            shreg   <= shreg_d;
            ptr     <= ptr_d;
            wr_addr <= wr_addr_d;
            wr_data <= wr_data_d;
            rd_addr <= rd_addr_d;
            ack_on  <= ack_on_d;
            rw      <= rw_d;
            got_ack <= got_ack_d;
            sda_oe  <= sda_oe_d;
            wr_stb  <= wr_stb_d;
            rd_req  <= rd_req_d;
            busy    <= busy_d;
        end
    end

    // Next-state logic: bus events first, then per-state bit handling on SCL edges
    always_comb begin
        state_d   = state;
        bit_cnt_d = bit_cnt;
        shreg_d   = shreg;
        ptr_d     = ptr;
        wr_addr_d = wr_addr;
        wr_data_d = wr_data;
        rd_addr_d = rd_addr;
        ack_on_d  = ack_on;
        rw_d      = rw;
        got_ack_d = got_ack;
        sda_oe_d  = sda_oe;
        wr_stb_d  = 1'b0;
        rd_req_d  = 1'b0;
        busy_d    = busy;

        if (start_ev) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            ack_on_d  = 1'b0;
            got_ack_d = 1'b0;
        end else if (stop_ev) begin
            state_d   = IDLE;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            ack_on_d  = 1'b0;
            got_ack_d = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                end
                ADDR: begin
                    if (scl_rise) begin
                        shreg_d   = byte_in;
                        bit_cnt_d = bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            if (byte_in[7:1] == DEV_ADDR) begin
                                state_d  = ADDR_ACK;
                                rw_d     = byte_in[0];
                                busy_d   = 1'b1;
                                ack_on_d = 1'b0;
                            end else begin
                                state_d = WAIT_STOP;
                            end
                        end
                    end
                end
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!ack_on) begin
                            sda_oe_d = 1'b1;
                            ack_on_d = 1'b1;
                            if (state == ADDR_ACK && rw) begin
                                rd_req_d  = 1'b1;
                                rd_addr_d = ptr;
                            end
                        end else begin
                            ack_on_d  = 1'b0;
                            bit_cnt_d = '0;
                            sda_oe_d  = 1'b0;
                            if (state == ADDR_ACK && rw) begin
                                state_d  = RDATA;
                                shreg_d  = rd_buf;
                                sda_oe_d = ~rd_buf[7];
                            end else if (state == ADDR_ACK) begin
                                state_d = PTR;
                            end else begin
                                state_d = WDATA;
                            end
                        end
                    end
                end
                PTR: begin
                    if (scl_rise) begin
                        shreg_d   = byte_in;
                        bit_cnt_d = bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            ptr_d   = byte_in[AW-1:0];
                            state_d = PTR_ACK;
                        end
                    end
                end
                WDATA: begin
                    if (scl_rise) begin
                        shreg_d   = byte_in;
                        bit_cnt_d = bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            wr_addr_d = ptr;
                            wr_data_d = byte_in;
                            wr_stb_d  = 1'b1;
                            ptr_d     = ptr + 1'b1;
                            state_d   = WDATA_ACK;
                        end
                    end
                end
                RDATA: begin
                    if (scl_fall) begin
                        if (bit_cnt == 3'd7) begin
                            sda_oe_d  = 1'b0;
                            got_ack_d = 1'b0;
                            state_d   = RACK;
                        end else begin
                            shreg_d   = {shreg[6:0], 1'b0};
                            sda_oe_d  = ~shreg[6];
                            bit_cnt_d = bit_cnt + 1'b1;
                        end
                    end
                end
                RACK: begin
                    if (scl_rise && !got_ack) begin
                        if (!sda) begin
                            ptr_d     = ptr + 1'b1;
                            rd_addr_d = ptr + 1'b1;
                            rd_req_d  = 1'b1;
                            got_ack_d = 1'b1;
                        end else begin
                            state_d = WAIT_STOP;
                            busy_d  = 1'b0;
                        end
                    end else if (scl_fall && got_ack) begin
                        shreg_d   = rd_buf;
                        sda_oe_d  = ~rd_buf[7];
                        bit_cnt_d = '0;
                        got_ack_d = 1'b0;
                        state_d   = RDATA;
                    end
                end
                WAIT_STOP: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// tb/tb_i2c_target_regs.sv - randomized bit-banged I2C host checked against a register-window reference model
module tb_i2c_target_regs;

    localparam int Q = 8;

    logic       clk;
    logic       reset;
    logic       scl_h, sda_h;
    logic       scl_oe, sda_oe, wr_stb, rd_req, busy;
    logic [2:0] wr_addr, rd_addr;
    logic [7:0] wr_data, rd_data;
    logic       scl_line, sda_line;

    logic [7:0] fab_mem   [8];
    logic [7:0] init_vals [8];
    logic       mem_load;

    logic [7:0] ref_mem [8];
    int         ref_ptr;
    logic [7:0] wdat [4];

    logic [10:0] obs_wr [$];
    logic [2:0]  obs_rd [$];
    logic        oe_seen, busy_seen;

    int tests, fails;

    assign scl_line = scl_h & ~scl_oe;
    assign sda_line = sda_h & ~sda_oe;

    i2c_target_regs #(.DEV_ADDR(7'h3A), .AW(3), .FILT(3)) dut (
        .clk_clk     (clk),
        .reset_reset (reset),
        .scl_in      (scl_line),
        .sda_in      (sda_line),
        .scl_oe      (scl_oe),
        .sda_oe      (sda_oe),
        .wr_stb      (wr_stb),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_req      (rd_req),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fabric register file with a registered read port
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 8; i++) fab_mem[i] <= init_vals[i];
        end else if (wr_stb) begin
            fab_mem[wr_addr] <= wr_data;
        end
        rd_data <= fab_mem[rd_addr];
    end

    // Observe fabric-side strobes and bus driving
    always @(negedge clk) begin
        if (wr_stb) obs_wr.push_back({wr_addr, wr_data});
        if (rd_req) obs_rd.push_back(rd_addr);
        if (sda_oe) oe_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic qwait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_h = 1'b1; qwait(Q);
        scl_h = 1'b1; qwait(Q);
        sda_h = 1'b0; qwait(Q);
        scl_h = 1'b0; qwait(Q);
    endtask

    task automatic bus_stop();
        sda_h = 1'b0; qwait(Q);
        scl_h = 1'b1; qwait(Q);
        sda_h = 1'b1; qwait(2 * Q);
    endtask

    task automatic write_bit(input logic b, input logic glitch);
        sda_h = b; qwait(Q);
        scl_h = 1'b1; qwait(Q);
        if (glitch) begin
            sda_h = ~b; qwait(1);
            sda_h = b;  qwait(Q - 1);
        end else begin
            qwait(Q);
        end
        scl_h = 1'b0; qwait(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_h = 1'b1; qwait(Q);
        scl_h = 1'b1; qwait(Q);
        b = sda_line; qwait(Q);
        scl_h = 1'b0; qwait(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, input logic [7:0] gmask, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(b[i], gmask[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] b, input logic nack);
        for (int i = 7; i >= 0; i--) read_bit(b[i]);
        write_bit(nack, 1'b0);
    endtask

    task automatic do_write(input logic [7:0] pb, input int n, input logic [7:0] gmask);
        logic a;
        int   ea;
        obs_wr.delete();
        bus_start();
        write_byte(8'h74, gmask, a);
        check("aw_ack", 32'(a), 0);
        check("aw_busy", 32'(busy), 1);
        write_byte(pb, 8'h00, a);
        check("ptr_ack", 32'(a), 0);
        for (int i = 0; i < n; i++) begin
            write_byte(wdat[i], 8'h00, a);
            check("wd_ack", 32'(a), 0);
        end
        bus_stop();
        check("w_busy_end", 32'(busy), 0);
        check("wr_cnt", obs_wr.size(), n);
        for (int i = 0; i < n; i++) begin
            ea = (int'(pb) % 8 + i) % 8;
            if (i < obs_wr.size()) begin
                check("wr_addr", 32'(obs_wr[i][10:8]), ea);
                check("wr_data", 32'(obs_wr[i][7:0]), 32'(wdat[i]));
            end
            ref_mem[ea] = wdat[i];
        end
        ref_ptr = (int'(pb) % 8 + n) % 8;
    endtask

    task automatic do_read(input logic setp, input logic [7:0] pb, input int n);
        logic       a;
        logic [7:0] b;
        int         base;
        obs_wr.delete();
        bus_start();
        if (setp) begin
            write_byte(8'h74, 8'h00, a);
            check("rp_aw_ack", 32'(a), 0);
            write_byte(pb, 8'h00, a);
            check("rp_ptr_ack", 32'(a), 0);
            bus_start();
            ref_ptr = int'(pb) % 8;
        end
        obs_rd.delete();
        write_byte(8'h75, 8'h00, a);
        check("ar_ack", 32'(a), 0);
        check("ar_busy", 32'(busy), 1);
        base = ref_ptr;
        for (int i = 0; i < n; i++) begin
            read_byte(b, i == n - 1);
            check("rd_byte", 32'(b), 32'(ref_mem[(base + i) % 8]));
        end
        bus_stop();
        check("r_busy_end", 32'(busy), 0);
        check("rd_req_cnt", obs_rd.size(), n);
        for (int i = 0; i < n && i < obs_rd.size(); i++)
            check("rd_addr", 32'(obs_rd[i]), (base + i) % 8);
        check("r_no_wr", obs_wr.size(), 0);
        ref_ptr = (base + n - 1) % 8;
    endtask

    initial begin
        logic       a;
        logic [7:0] pb;
        logic [7:0] d;
        int         kind, n;

        tests = 0; fails = 0;
        scl_h = 1'b1; sda_h = 1'b1;
        reset = 1'b1; mem_load = 1'b1;
        oe_seen = 1'b0; busy_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            init_vals[i] = d;
            ref_mem[i]   = d;
        end
        ref_ptr = 0;
        qwait(5);
        mem_load = 1'b0;
        check("rst_sda_oe", 32'(sda_oe), 0);
        check("rst_scl_oe", 32'(scl_oe), 0);
        check("rst_wr_stb", 32'(wr_stb), 0);
        check("rst_rd_req", 32'(rd_req), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        check("rst_rd_addr", 32'(rd_addr), 0);
        reset = 1'b0;
        qwait(10);

        // Basic write at pointer 2
        wdat[0] = 8'hA5; wdat[1] = 8'h5A;
        do_write(8'h02, 2, 8'h00);

        // Pointer-write then repeated-start read across the wrap point
        do_read(1'b1, 8'h07, 2);

        // Foreign address is ignored entirely
        obs_wr.delete(); oe_seen = 1'b0; busy_seen = 1'b0;
        bus_start();
        write_byte(8'hA0, 8'h00, a);
        check("wa_addr_nack", 32'(a), 1);
        write_byte(8'h11, 8'h00, a);
        check("wa_data_nack", 32'(a), 1);
        bus_stop();
        check("wa_oe_seen", 32'(oe_seen), 0);
        check("wa_busy_seen", 32'(busy_seen), 0);
        check("wa_no_wr", obs_wr.size(), 0);

        // Single-cycle SDA pulses while SCL is high must not look like START/STOP
        wdat[0] = 8'h3C;
        do_write(8'h05, 1, 8'h18);
        do_read(1'b0, 8'h00, 1);

        // Reset during the fourth bit of a read byte
        bus_start();
        write_byte(8'h74, 8'h00, a);
        write_byte(8'h05, 8'h00, a);
        bus_start();
        write_byte(8'h75, 8'h00, a);
        check("rr_ack", 32'(a), 0);
        for (int i = 0; i < 3; i++) read_bit(a);
        sda_h = 1'b1; qwait(Q);
        scl_h = 1'b1; qwait(Q / 2);
        reset = 1'b1; qwait(1);
        reset = 1'b0; qwait(1);
        check("rr_sda_oe", 32'(sda_oe), 0);
        check("rr_busy", 32'(busy), 0);
        qwait(Q);
        scl_h = 1'b0; qwait(Q);
        bus_stop();
        ref_ptr = 0;
        do_read(1'b0, 8'h00, 1);

        // STOP after three bits of a data byte
        obs_wr.delete();
        bus_start();
        write_byte(8'h74, 8'h00, a);
        write_byte(8'h04, 8'h00, a);
        check("sm_ptr_ack", 32'(a), 0);
        write_bit(1'b1, 1'b0);
        write_bit(1'b0, 1'b0);
        write_bit(1'b1, 1'b0);
        bus_stop();
        check("sm_no_wr", obs_wr.size(), 0);
        check("sm_busy", 32'(busy), 0);
        ref_ptr = 4;
        do_read(1'b0, 8'h00, 1);

        // Randomized mix of writes, pointer reads and current-address reads
        for (int t = 0; t < 12; t++) begin
            kind = $urandom_range(0, 2);
            pb   = 8'($urandom);
            n    = $urandom_range(1, 4);
            if (kind == 0) begin
                for (int i = 0; i < 4; i++) wdat[i] = 8'($urandom);
                do_write(pb, n, 8'h00);
            end else if (kind == 1) begin
                do_read(1'b1, pb, n);
            end else begin
                do_read(1'b0, 8'h00, n);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
